// File: rtl/line_encoder_148_if.sv
// Request/response bundle for line_encoder_148.
interface line_encoder_148_if;
  logic [7:0] lines_n;
  logic       enable_n;
  logic [2:0] code;
  logic       valid;
  logic       gs_n;
  logic       eo_n;
  logic       multi_err;

  modport master (
    output lines_n, enable_n,
    input  code, valid, gs_n, eo_n, multi_err
  );

  modport slave (
    input  lines_n, enable_n,
    output code, valid, gs_n, eo_n, multi_err
  );
endinterface

// File: rtl/line_encoder_148.sv
// Filtered, registered 8-to-3 priority encoder with 74HC148-style cascade outputs.
module line_encoder_148 #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  line_encoder_148_if.slave bus
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [7:0] s1_q, s2_q;
  logic [7:0] cand_q, cand_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  state_t     state_q, state_d;

  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       gs_n_q, gs_n_d;
  logic       eo_n_q, eo_n_d;
  logic       multi_err_q, multi_err_d;

  logic       en;
  logic [2:0] top_idx;

  assign en = ~bus.enable_n;

  // Two-flop synchroniser; keeps running while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= bus.lines_n;
      s2_q <= s1_q;
    end
  end

  // Stability filter, acceptance register and IDLE/ACTIVE next state.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    state_d = state_q;
    if (!en) begin
      cnt_d   = '0;
      acc_d   = '1;
      state_d = IDLE;
    end else begin
      if (cnt_q == '0 || s2_q != cand_q) begin
        cand_d = s2_q;
        cnt_d  = 4'd1;
      end else if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + 4'd1;
      end
      if (cnt_d == CNT_MAX && cnt_q != CNT_MAX) begin
        acc_d = cand_q;
        case (state_q)
          IDLE:    if (cand_q != '1) state_d = ACTIVE;
          ACTIVE:  if (cand_q == '1) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Output stage next values from the accepted pattern.
  always_comb begin
    top_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!acc_q[i]) top_idx = 3'(i);
    end
    code_d      = en ? top_idx : '0;
    gs_n_d      = ~(en & (state_q == ACTIVE));
    // eo_n waits one enabled edge (filter running) so a lower stage never sees a stale enable.
    eo_n_d      = ~(en & (cnt_q != '0) & (state_q == IDLE));
    multi_err_d = en & ($countones(~acc_q) > 1);
    valid_d     = ~gs_n_d & (gs_n_q | (code_d != code_q));
  end

  // Filter, FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q      <= '1;
      cnt_q       <= '0;
      acc_q       <= '1;
      state_q     <= IDLE;
      code_q      <= '0;
      valid_q     <= 1'b0;
      gs_n_q      <= 1'b1;
      eo_n_q      <= 1'b1;
      multi_err_q <= 1'b0;
    end else begin
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      state_q     <= state_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      gs_n_q      <= gs_n_d;
      eo_n_q      <= eo_n_d;
      multi_err_q <= multi_err_d;
    end
  end

  assign bus.code      = code_q;
  assign bus.valid     = valid_q;
  assign bus.gs_n      = gs_n_q;
  assign bus.eo_n      = eo_n_q;
  assign bus.multi_err = multi_err_q;

endmodule

// File: tb/tb_line_encoder_148.sv
// Bench for line_encoder_148: directed scenarios, random stimulus against a run-length model, cascade.
module tb_line_encoder_148;

  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  line_encoder_148_if u_if ();
  line_encoder_148_if hi_if ();
  line_encoder_148_if lo_if ();

  assign lo_if.enable_n = hi_if.eo_n;

  line_encoder_148 #(.STABLE_CYCLES(STABLE)) u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));
  line_encoder_148 #(.STABLE_CYCLES(STABLE)) u_hi  (.clk(clk), .rst(rst), .bus(hi_if.slave));
  line_encoder_148 #(.STABLE_CYCLES(STABLE)) u_lo  (.clk(clk), .rst(rst), .bus(lo_if.slave));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: synchroniser pipe, run length of identical samples, accepted pattern.
  logic [7:0] m_s1, m_s2, m_run_val, m_acc;
  int         m_run_len;
  logic [2:0] m_code;
  logic       m_gs_n, m_eo_n, m_me, m_valid, m_en_hist;

  function automatic int top_low(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      if (!v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_s1 = 8'hFF; m_s2 = 8'hFF; m_run_val = 8'hFF; m_acc = 8'hFF;
    m_run_len = 0; m_code = 3'd0; m_gs_n = 1'b1; m_eo_n = 1'b1;
    m_me = 1'b0; m_valid = 1'b0; m_en_hist = 1'b0;
  endtask

  task automatic model_edge();
    int lows;
    int top;
    if (rst) begin
      model_reset();
      return;
    end
    if (u_if.enable_n) begin
      m_code = 3'd0; m_gs_n = 1'b1; m_eo_n = 1'b1; m_me = 1'b0; m_valid = 1'b0;
      m_run_len = 0; m_acc = 8'hFF; m_en_hist = 1'b0;
    end else begin
      lows    = $countones(~m_acc);
      top     = top_low({8'hFF, m_acc});
      m_valid = (lows > 0) && (m_gs_n || (3'(top) != m_code));
      m_gs_n  = !(lows > 0);
      m_eo_n  = !(lows == 0 && m_en_hist);
      m_me    = (lows > 1);
      m_code  = 3'(top);
      if (m_run_len > 0 && m_s2 == m_run_val) m_run_len++;
      else begin
        m_run_val = m_s2;
        m_run_len = 1;
      end
      if (m_run_len == STABLE) m_acc = m_run_val;
      m_en_hist = 1'b1;
    end
    m_s2 = m_s1;
    m_s1 = u_if.lines_n;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_eq("code", 16'(u_if.code), 16'(m_code));
    check_eq("gs_n", 16'(u_if.gs_n), 16'(m_gs_n));
    check_eq("eo_n", 16'(u_if.eo_n), 16'(m_eo_n));
    check_eq("valid", 16'(u_if.valid), 16'(m_valid));
    check_eq("multi_err", 16'(u_if.multi_err), 16'(m_me));
  endtask

  task automatic casc(input logic [15:0] l);
    logic [3:0] code4;
    logic       lo_gs_exp;
    hi_if.lines_n = l[15:8];
    lo_if.lines_n = l[7:0];
    repeat (20) @(posedge clk);
    #1;
    code4     = {~hi_if.gs_n, hi_if.code | lo_if.code};
    lo_gs_exp = !((l[15:8] == 8'hFF) && (l[7:0] != 8'hFF));
    check_eq($sformatf("casc_code_%h", l), 16'(code4), 16'(top_low(l)));
    check_eq($sformatf("casc_lo_gs_%h", l), 16'(lo_if.gs_n), 16'(lo_gs_exp));
  endtask

  initial begin
    logic seen_a, seen_b;
    logic [7:0] pat;
    int dur;

    rst = 1'b1;
    u_if.lines_n = 8'hFF;  u_if.enable_n = 1'b0;
    hi_if.lines_n = 8'hFF; hi_if.enable_n = 1'b0;
    lo_if.lines_n = 8'hFF;
    model_reset();

    tick(); tick();
    check_eq("rst_code", 16'(u_if.code), 16'd0);
    check_eq("rst_gs_n", 16'(u_if.gs_n), 16'd1);
    check_eq("rst_eo_n", 16'(u_if.eo_n), 16'd1);
    rst = 1'b0;

    // Idle lines: never a valid, eo_n low once the filter runs.
    seen_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (u_if.valid) seen_a = 1'b1;
    end
    check_eq("idle_valid_seen", 16'(seen_a), 16'd0);
    check_eq("idle_eo_n", 16'(u_if.eo_n), 16'd0);

    // Latency: single low line 5, outputs at edge 6.
    u_if.lines_n = 8'b1101_1111;
    for (int k = 0; k <= 6; k++) begin
      tick();
      check_eq($sformatf("lat_valid_e%0d", k), 16'(u_if.valid), 16'(k == 6));
    end
    check_eq("lat_code", 16'(u_if.code), 16'd5);
    check_eq("lat_gs_n", 16'(u_if.gs_n), 16'd0);
    check_eq("lat_eo_n", 16'(u_if.eo_n), 16'd1);
    check_eq("lat_me", 16'(u_if.multi_err), 16'd0);
    tick();
    check_eq("lat_valid_once", 16'(u_if.valid), 16'd0);

    // Multiple lines, then release of a lower-priority line.
    u_if.lines_n = 8'b0111_1110;
    repeat (8) tick();
    check_eq("multi_code", 16'(u_if.code), 16'd7);
    check_eq("multi_me", 16'(u_if.multi_err), 16'd1);
    u_if.lines_n = 8'b0111_1111;
    seen_a = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      if (u_if.valid) seen_a = 1'b1;
      check_eq($sformatf("rel_me_e%0d", k), 16'(u_if.multi_err), 16'(k < 6));
      check_eq("rel_code", 16'(u_if.code), 16'd7);
    end
    check_eq("rel_valid_seen", 16'(seen_a), 16'd0);

    // Glitches: 3 samples rejected, 4 accepted.
    u_if.lines_n = 8'hFF;
    repeat (8) tick();
    u_if.lines_n = 8'hF7;
    repeat (3) tick();
    u_if.lines_n = 8'hFF;
    seen_a = 1'b0; seen_b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (u_if.valid) seen_a = 1'b1;
      if (!u_if.gs_n) seen_b = 1'b1;
    end
    check_eq("glitch3_valid", 16'(seen_a), 16'd0);
    check_eq("glitch3_gs", 16'(seen_b), 16'd0);
    u_if.lines_n = 8'hF7;
    seen_a = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k == 4) u_if.lines_n = 8'hFF;
      tick();
      if (u_if.valid && u_if.code == 3'd3) seen_a = 1'b1;
    end
    check_eq("glitch4_accept", 16'(seen_a), 16'd1);

    // Disable while code=5, then re-enable with lines held.
    u_if.lines_n = 8'b1101_1111;
    repeat (8) tick();
    u_if.enable_n = 1'b1;
    tick();
    check_eq("dis_gs_n", 16'(u_if.gs_n), 16'd1);
    check_eq("dis_eo_n", 16'(u_if.eo_n), 16'd1);
    check_eq("dis_code", 16'(u_if.code), 16'd0);
    repeat (2) tick();
    u_if.enable_n = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      tick();
      check_eq($sformatf("reen_valid_e%0d", k), 16'(u_if.valid), 16'(k == 4));
      check_eq($sformatf("reen_eo_n_e%0d", k), 16'(u_if.eo_n), 16'(!(k >= 1 && k <= 3)));
    end
    check_eq("reen_code", 16'(u_if.code), 16'd5);

    // Reset mid-filter, with enable_n high too: reset wins.
    u_if.lines_n = 8'hFF;
    repeat (8) tick();
    u_if.lines_n = 8'b1011_1111;
    repeat (3) tick();
    rst = 1'b1; u_if.enable_n = 1'b1;
    tick();
    check_eq("mrst_gs_n", 16'(u_if.gs_n), 16'd1);
    check_eq("mrst_code", 16'(u_if.code), 16'd0);
    rst = 1'b0; u_if.enable_n = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      tick();
      check_eq($sformatf("mrst_valid_e%0d", k), 16'(u_if.valid), 16'(k == 6));
    end
    check_eq("mrst_reaccept", 16'(u_if.code), 16'd6);

    // Random segments.
    for (int s = 0; s < 500; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          pat = 8'hFF;
          pat[$urandom_range(0, 7)] = 1'b0;
        end
        3:       pat = 8'hFF;
        8:       pat = u_if.lines_n;
        default: pat = 8'($urandom);
      endcase
      u_if.lines_n  = pat;
      u_if.enable_n = ($urandom_range(0, 11) == 0);
      rst           = ($urandom_range(0, 39) == 0);
      dur = $urandom_range(1, 8);
      for (int k = 0; k < dur; k++) begin
        tick();
        rst = 1'b0;
      end
    end
    u_if.enable_n = 1'b0;

    // Cascade of two stages.
    casc(16'hFDFF);
    casc(16'hFFFB);
    casc(16'hFDFB);
    casc(16'hFFFF);
    for (int r = 0; r < 6; r++) begin
      casc(16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
